// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC frame sequencer and its register file.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_RUN,
        ST_PUB
    } seq_state_t;

    localparam logic [2:0]  REG_RATE    = 3'd0;
    localparam logic [2:0]  REG_CTRL    = 3'd1;
    localparam logic [2:0]  REG_STATUS  = 3'd2;
    localparam logic [2:0]  REG_FCNT    = 3'd3;
    localparam logic [2:0]  REG_THR     = 3'd4;

    localparam logic [15:0] UNMAPPED_RD = 16'h0bad;
    localparam int          MIN_RATE    = 15;

endpackage

// File: rtl/lpc_frame_seq_if.sv
// Avalon-MM host port of the frame sequencer; readdata is registered by the slave.
interface lpc_frame_seq_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/lpc_seq_csr.sv
// Host register file: rate (clamped), enable, W1C status, frame counter, threshold shift.
// Read data appears one cycle after the read strobe and is zero otherwise.
module lpc_seq_csr
  import lpc_pkg::*;
#(
  parameter int AW       = 8,
  parameter int RATE_DEF = 159
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lpc_frame_seq_if.slave       avm,
  input  logic                 busy,
  input  logic                 overrun_set,
  input  logic                 timeout_set,
  input  logic                 frame_inc,
  output logic [AW-1:0]        rate,
  output logic                 enable,
  output logic [2:0]           thr_shift
);

  logic        overrun;
  logic        timeout;
  logic [15:0] frame_cnt;
  logic [15:0] rd_mux;
  logic [AW-1:0] rate_wr;
  logic        status_wr;

  assign status_wr = avm.write && (avm.address == REG_STATUS);
  assign rate_wr   = (avm.writedata[AW-1:0] < AW'(MIN_RATE)) ? AW'(MIN_RATE)
                                                             : avm.writedata[AW-1:0];

  always_comb begin
    rd_mux = UNMAPPED_RD;
    case (avm.address)
      REG_RATE:   rd_mux = 16'(rate);
      REG_CTRL:   rd_mux = {15'd0, enable};
      REG_STATUS: rd_mux = {13'd0, timeout, overrun, busy};
      REG_FCNT:   rd_mux = frame_cnt;
      REG_THR:    rd_mux = {13'd0, thr_shift};
      default:    rd_mux = UNMAPPED_RD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate         <= AW'(RATE_DEF);
      enable       <= 1'b0;
      thr_shift    <= 3'd2;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      frame_cnt    <= 16'd0;
      avm.readdata <= 16'd0;
    end else begin
      if (avm.write) begin
        case (avm.address)
          REG_RATE: rate      <= rate_wr;
          REG_CTRL: enable    <= avm.writedata[0];
          REG_THR:  thr_shift <= avm.writedata[2:0];
          default:  ;
        endcase
      end
      // A hardware set in the same cycle as a host clear wins.
      overrun <= overrun_set | (overrun & ~(status_wr & avm.writedata[1]));
      timeout <= timeout_set | (timeout & ~(status_wr & avm.writedata[2]));
      if (frame_inc)
        frame_cnt <= frame_cnt + 16'd1;
      avm.readdata <= avm.read ? rd_mux : 16'd0;
    end
  end

endmodule

// File: rtl/lpc_frame_seq.sv
// Frame sequencer: counts samples into a double-banked buffer and, per completed
// frame, resets/starts the LDR solver, streams the bank to freq_est and publishes.
module lpc_frame_seq
  import lpc_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RATE_DEF = 159,
  parameter int TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_v,
  input  logic signed [DW-1:0] peak,
  input  logic                 ldr_done,
  output logic [AW:0]          wr_addr,
  output logic                 wr_en,
  output logic [AW:0]          rd_addr,
  output logic                 freq_est_v,
  output logic signed [DW-1:0] threshold,
  output logic                 peak_en,
  output logic                 peak_clr,
  output logic                 ldr_rst,
  output logic                 ldr_start,
  output logic                 coef_load,
  lpc_frame_seq_if.slave       avm
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t    state, state_nxt;
  logic [AW-1:0] rate_reg, act_rate, cur_rate, run_rate;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          wr_bank, rd_bank;
  logic          enable, enable_q, en_rise;
  logic          frame_rdy, frame_rdy_q;
  logic          stream_on, ldr_seen;
  logic [TW-1:0] run_cnt;
  logic [2:0]    thr_shift;
  logic          busy, overrun_set, timeout_set;

  lpc_seq_csr #(.AW(AW), .RATE_DEF(RATE_DEF)) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .avm         (avm),
    .busy        (busy),
    .overrun_set (overrun_set),
    .timeout_set (timeout_set),
    .frame_inc   (coef_load),
    .rate        (rate_reg),
    .enable      (enable),
    .thr_shift   (thr_shift)
  );

  // The register value takes effect only at enable rise or a frame boundary.
  assign en_rise   = enable & ~enable_q;
  assign cur_rate  = en_rise ? rate_reg : act_rate;
  assign wr_en     = sample_v & enable;
  assign frame_rdy = wr_en & (wr_idx == cur_rate);
  assign wr_addr   = {wr_bank, wr_idx};
  assign rd_addr   = {rd_bank, rd_idx};
  assign peak_en   = enable;
  assign peak_clr  = en_rise | frame_rdy_q;

  assign busy        = (state != ST_IDLE);
  assign overrun_set = frame_rdy & busy;
  assign freq_est_v  = (state == ST_START) | ((state == ST_RUN) & stream_on);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q    <= 1'b0;
      frame_rdy_q <= 1'b0;
      act_rate    <= AW'(RATE_DEF);
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
    end else begin
      enable_q    <= enable;
      frame_rdy_q <= frame_rdy;
      if (en_rise || frame_rdy)
        act_rate <= rate_reg;
      if (!enable) begin
        wr_idx <= '0;
      end else if (wr_en) begin
        if (frame_rdy) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + AW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ldr_rst     = 1'b0;
    ldr_start   = 1'b0;
    coef_load   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE:  if (frame_rdy) state_nxt = ST_CLR;
      ST_CLR: begin
        ldr_rst   = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        ldr_start = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if ((ldr_seen | ldr_done) & ~stream_on) begin
          state_nxt = ST_PUB;
        end else if (run_cnt == TW'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_PUB: begin
        coef_load = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      threshold <= '0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      run_rate  <= '0;
      stream_on <= 1'b0;
      ldr_seen  <= 1'b0;
      run_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          // The bank just filled is the one being read; its length is frozen here.
          if (frame_rdy) begin
            threshold <= peak >>> thr_shift;
            rd_bank   <= wr_bank;
            run_rate  <= cur_rate;
          end
        end
        ST_CLR: begin
          rd_idx    <= '0;
          stream_on <= 1'b0;
          ldr_seen  <= 1'b0;
          run_cnt   <= '0;
        end
        ST_START: begin
          rd_idx    <= AW'(1);
          stream_on <= 1'b1;
        end
        ST_RUN: begin
          run_cnt <= run_cnt + TW'(1);
          if (ldr_done)
            ldr_seen <= 1'b1;
          if (stream_on) begin
            if (rd_idx == run_rate)
              stream_on <= 1'b0;
            else
              rd_idx <= rd_idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_frame_seq.sv
// Randomised bench for lpc_frame_seq: frames are predicted from sample counts and rates.
module tb_lpc_frame_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_v = 1'b0;
  logic               ldr_done = 1'b0;
  logic signed [15:0] peak = '0;
  logic [8:0]         wr_addr, rd_addr;
  logic               wr_en, freq_est_v, peak_en, peak_clr, ldr_rst, ldr_start, coef_load;
  logic signed [15:0] threshold;

  lpc_frame_seq_if avm ();

  lpc_frame_seq #(.AW(8), .DW(16), .RATE_DEF(159), .TIMEOUT(1023)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_v   (sample_v),
    .peak       (peak),
    .ldr_done   (ldr_done),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .freq_est_v (freq_est_v),
    .threshold  (threshold),
    .peak_en    (peak_en),
    .peak_clr   (peak_clr),
    .ldr_rst    (ldr_rst),
    .ldr_start  (ldr_start),
    .coef_load  (coef_load),
    .avm        (avm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Observation log, sampled on the falling edge.
  int         cyc = 0, n_rst = 0, n_start = 0, n_coef = 0, n_pclr = 0;
  int         rst_cyc = 0, start_cyc = 0, last_wr_cyc = 0;
  logic [8:0] wq[$];
  logic [8:0] rq[$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin wq.push_back(wr_addr); last_wr_cyc = cyc; end
    if (freq_est_v) rq.push_back(rd_addr);
    if (ldr_rst) begin n_rst++; rst_cyc = cyc; end
    if (ldr_start) begin n_start++; start_cyc = cyc; end
    if (coef_load) n_coef++;
    if (peak_clr) n_pclr++;
  end

  // LDR stand-in: raises done ldr_delay cycles after start; negative means never.
  int ldr_delay = 5;
  int ldr_cnt = -1;
  always @(negedge clk) begin
    if (!rst_n || ldr_rst) begin
      ldr_done = 1'b0;
      ldr_cnt  = -1;
    end else if (ldr_start) begin
      ldr_cnt = ldr_delay;
    end else if (ldr_cnt > 0) begin
      ldr_cnt--;
    end
    if (ldr_cnt == 0 && rst_n) ldr_done = 1'b1;
  end

  task automatic avm_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    avm.address = a; avm.writedata = d; avm.write = 1'b1;
    @(posedge clk); #1;
    avm.write = 1'b0;
  endtask

  task automatic avm_read(input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    avm.address = a; avm.read = 1'b1;
    @(posedge clk); #1;
    avm.read = 1'b0;
    @(negedge clk);
    d = avm.readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    avm_read(a, d);
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic run_samples(input int n, input int gmin, input int gmax);
    int sent = 0;
    int gap = 0;
    while (sent < n) begin
      @(posedge clk); #1;
      if (gap == 0) begin
        sample_v = 1'b1;
        sent++;
        gap = int'($urandom_range(gmax, gmin));
      end else begin
        sample_v = 1'b0;
        gap--;
      end
    end
    @(posedge clk); #1;
    sample_v = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Arithmetic right shift expressed as floor division.
  function automatic logic [31:0] thr_model(input int p, input int s);
    int r;
    int d = 1 << s;
    if (p >= 0) r = p / d;
    else        r = -((-p + d - 1) / d);
    return {16'h0, r[15:0]};
  endfunction

  // One complete frame of len samples into bank, followed by its analysis pass.
  task automatic do_frame(input int len, input int bank, input int gmax, input int wait_cyc,
                          input string tag);
    int c0 = n_coef;
    wq.delete();
    rq.delete();
    run_samples(len, 0, gmax);
    repeat (wait_cyc) @(posedge clk);
    chk({tag, "_nwr"}, wq.size(), len);
    for (int k = 0; k < wq.size() && k < len; k++)
      chk({tag, "_wraddr"}, 32'(wq[k]), (bank << 8) | k);
    chk({tag, "_nrd"}, rq.size(), len);
    for (int k = 0; k < rq.size() && k < len; k++)
      chk({tag, "_rdaddr"}, 32'(rq[k]), (bank << 8) | k);
    chk({tag, "_rst_after_last"}, rst_cyc - last_wr_cyc, 1);
    chk({tag, "_start_after_rst"}, start_cyc - rst_cyc, 1);
    chk({tag, "_ncoef"}, n_coef - c0, 1);
  endtask

  initial begin
    int r, sh, p, c0, p0, n0;
    avm.address = '0; avm.read = 1'b0; avm.write = 1'b0; avm.writedata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({wr_addr, rd_addr, freq_est_v, threshold, peak_en, peak_clr,
                            ldr_rst, ldr_start, coef_load, wr_en}), 0);
    chk("rst_readdata", 32'(avm.readdata), 0);
    rst_n = 1'b1;
    rd_chk("rst_rate", 3'd0, 16'd159);
    rd_chk("rst_ctrl", 3'd1, 16'd0);
    rd_chk("rst_status", 3'd2, 16'd0);
    rd_chk("rst_fcnt", 3'd3, 16'd0);
    rd_chk("rst_thr", 3'd4, 16'd2);

    // Default-rate frame with random gaps and LDR latency
    ldr_delay = int'($urandom_range(200, 0));
    peak = 16'($urandom);
    p0 = n_pclr;
    avm_write(3'd1, 16'd1);
    do_frame(160, 0, 2, 420, "t1");
    @(negedge clk);
    chk("t1_bank_toggled", 32'(wr_addr), 32'h100);
    chk("t1_peak_clr", n_pclr - p0, 2);
    chk("t1_thr", {16'h0, threshold}, thr_model(int'(peak), 2));
    rd_chk("t1_fcnt", 3'd3, 16'd1);

    // Threshold derivation over random peaks/shifts, alternating banks
    do_reset();
    r = int'($urandom_range(40, 15));
    ldr_delay = int'($urandom_range(40, 0));
    avm_write(3'd0, 16'(r));
    avm_write(3'd1, 16'd1);
    for (int f = 0; f < 6; f++) begin
      sh = (f == 0) ? 2 : (f == 1) ? 3 : int'($urandom_range(7, 0));
      p  = (f == 0) ? -32768 : (f == 1) ? 1000 : int'($signed(16'($urandom)));
      avm_write(3'd4, 16'(sh));
      peak = 16'(p);
      do_frame(r + 1, f % 2, 2, r + 70, "t2");
      chk("t2_thr", {16'h0, threshold}, thr_model(p, sh));
    end
    rd_chk("t2_fcnt", 3'd3, 16'd6);

    // RUN timeout when LDR never finishes
    do_reset();
    ldr_delay = -1;
    avm_write(3'd0, 16'd15);
    avm_write(3'd1, 16'd1);
    c0 = n_coef;
    rq.delete();
    run_samples(16, 0, 0);
    repeat (1000) @(posedge clk);
    rd_chk("t3_still_running", 3'd2, 16'h1);
    repeat (40) @(posedge clk);
    rd_chk("t3_timeout_set", 3'd2, 16'h4);
    chk("t3_no_coef", n_coef - c0, 0);
    chk("t3_stream_len", rq.size(), 16);
    rd_chk("t3_fcnt", 3'd3, 16'd0);
    avm_write(3'd2, 16'h4);
    rd_chk("t3_timeout_clr", 3'd2, 16'h0);

    // Overrun: second frame arrives while LDR is still working
    do_reset();
    ldr_delay = 40;
    avm_write(3'd0, 16'd15);
    avm_write(3'd1, 16'd1);
    c0 = n_coef;
    wq.delete();
    run_samples(32, 0, 0);
    repeat (80) @(posedge clk);
    chk("t4_one_coef", n_coef - c0, 1);
    rd_chk("t4_overrun", 3'd2, 16'h2);
    rd_chk("t4_fcnt", 3'd3, 16'd1);
    chk("t4_nwr", wq.size(), 32);
    for (int k = 0; k < wq.size() && k < 32; k++)
      chk("t4_wraddr", 32'(wq[k]), ((k / 16) << 8) | (k % 16));
    avm_write(3'd2, 16'h2);
    rd_chk("t4_overrun_clr", 3'd2, 16'h0);

    // Rate shadowing: mid-frame write takes effect on the next frame
    do_reset();
    ldr_delay = 5;
    avm_write(3'd1, 16'd1);
    wq.delete();
    rq.delete();
    run_samples(60, 1, 3);
    avm_write(3'd0, 16'd99);
    run_samples(200, 1, 3);
    repeat (150) @(posedge clk);
    chk("t5_nwr", wq.size(), 260);
    for (int k = 0; k < wq.size() && k < 260; k++)
      chk("t5_wraddr", 32'(wq[k]), (k < 160) ? k : (256 + k - 160));
    chk("t5_nrd", rq.size(), 260);
    for (int k = 0; k < rq.size() && k < 260; k++)
      chk("t5_rdaddr", 32'(rq[k]), (k < 160) ? k : (256 + k - 160));
    rd_chk("t5_fcnt", 3'd3, 16'd2);
    avm_write(3'd0, 16'd3);
    rd_chk("t5_rate_clamp", 3'd0, 16'd15);

    // Enable toggled mid-frame restarts collection; unmapped reads
    do_reset();
    n0 = n_rst;
    avm_write(3'd1, 16'd1);
    run_samples(50, 0, 2);
    avm_write(3'd1, 16'd0);
    p0 = n_pclr;
    avm_write(3'd1, 16'd1);
    repeat (2) @(posedge clk);
    chk("t6_peak_clr_once", n_pclr - p0, 1);
    wq.delete();
    run_samples(5, 0, 0);
    for (int k = 0; k < 5; k++)
      chk("t6_restart_idx", (k < wq.size()) ? 32'(wq[k]) : 32'hffff, k);
    chk("t6_no_frame", n_rst - n0, 0);
    rd_chk("t6_unmapped7", 3'd7, 16'h0bad);
    @(negedge clk);
    chk("t6_idle_readdata", 32'(avm.readdata), 0);
    rd_chk("t6_unmapped", 3'(int'($urandom_range(6, 5))), 16'h0bad);

    // Asynchronous reset in the middle of an analysis pass
    do_reset();
    ldr_delay = -1;
    peak = 16'sh4000;
    avm_write(3'd0, 16'd15);
    avm_write(3'd1, 16'd1);
    run_samples(16, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t7_pre_stream", 32'(freq_est_v), 1);
    chk("t7_pre_thr", {16'h0, threshold}, 32'h1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_async_clear", 32'({wr_addr, rd_addr, freq_est_v, threshold, peak_en,
                               ldr_rst, ldr_start, coef_load}), 0);
    rst_n = 1'b1;
    rd_chk("t7_rate", 3'd0, 16'd159);
    rd_chk("t7_status", 3'd2, 16'd0);
    rd_chk("t7_ctrl", 3'd1, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
